// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and types for the banked register file and its pending-result scoreboard.
package regfile_scoreboard_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREG  = 32;
    localparam int DEF_NBANK = 2;
    localparam int DEF_NREAD = 3;
    localparam int DEF_LAT_W = 5;

    localparam int IDX_W  = $clog2(DEF_NREG);
    localparam int BANK_W = $clog2(DEF_NBANK);
    localparam int DEF_AW = BANK_W + IDX_W;

    localparam logic [BANK_W-1:0] BANK_GPR = BANK_W'(0);
    localparam logic [BANK_W-1:0] BANK_FPR = BANK_W'(1);

    typedef struct packed {
        logic [BANK_W-1:0] bank;
        logic [IDX_W-1:0]  idx;
    } regaddr_t;

    typedef logic [DEF_LAT_W-1:0] lat_t;

    localparam lat_t LAT_ALU  = lat_t'(1);
    localparam lat_t LAT_LOAD = lat_t'(3);
    localparam lat_t LAT_FPU  = lat_t'(6);

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/write-back side bus of the register file: read ports, issue request, write-back and flush.
interface regfile_scoreboard_if #(
    parameter int XLEN  = regfile_scoreboard_pkg::DEF_XLEN,
    parameter int AW    = regfile_scoreboard_pkg::DEF_AW,
    parameter int NREAD = regfile_scoreboard_pkg::DEF_NREAD,
    parameter int LAT_W = regfile_scoreboard_pkg::DEF_LAT_W
);
    logic [NREAD*AW-1:0]   rd_addr;
    logic [NREAD-1:0]      rd_used;
    logic [NREAD*XLEN-1:0] rd_data;
    logic [NREAD-1:0]      rd_ready;
    logic                  iss_valid;
    logic                  iss_we;
    logic [AW-1:0]         iss_dst;
    logic [LAT_W-1:0]      iss_lat;
    logic                  stall;
    logic                  wb_en;
    logic [AW-1:0]         wb_dst;
    logic [XLEN-1:0]       wb_data;
    logic                  flush;

    modport master (
        output rd_addr, rd_used, iss_valid, iss_we, iss_dst, iss_lat,
        output wb_en, wb_dst, wb_data, flush,
        input  rd_data, rd_ready, stall
    );

    modport slave (
        input  rd_addr, rd_used, iss_valid, iss_we, iss_dst, iss_lat,
        input  wb_en, wb_dst, wb_data, flush,
        output rd_data, rd_ready, stall
    );
endinterface

// File: rtl/regfile_scoreboard_sb_counter.sv
// One register's pending-result countdown: clear beats load beats write-back clear beats decrement.
module sb_counter #(
    parameter int LAT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    input  logic             wb_clr,
    output logic [LAT_W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (rst || clear)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (wb_clr)
            cnt <= '0;
        else if (cnt != '0)
            cnt <= cnt - LAT_W'(1);
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-bank register file with write-back bypass and a per-register latency scoreboard
// that stalls decode on RAW and WAW hazards against in-flight results.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int XLEN      = DEF_XLEN,
    parameter int NREG      = DEF_NREG,
    parameter int NBANK     = DEF_NBANK,
    parameter int NREAD     = DEF_NREAD,
    parameter int LAT_W     = DEF_LAT_W,
    parameter bit ZERO_HARD = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    regfile_scoreboard_if.slave bus
);
    localparam int AW   = $clog2(NBANK) + $clog2(NREG);
    localparam int NTOT = 1 << AW;

    logic [XLEN-1:0]            mem [NTOT];
    logic [NTOT-1:0][LAT_W-1:0] cnt;
    logic [NTOT-1:0]            addr_ok;
    logic [NREAD-1:0][XLEN-1:0] rd_data_v;
    logic [NREAD-1:0]           rd_ready_v;
    logic [LAT_W-1:0]           load_val;
    logic                       dst_hit;
    logic                       raw;
    logic                       waw;
    logic                       stall_int;
    logic                       accept;

    function automatic logic is_hard0(input logic [AW-1:0] a);
        return ZERO_HARD && (a == '0);
    endfunction

    // Nonexistent banks and the hardwired zero get no counter, so they can never be pending.
    for (genvar r = 0; r < NTOT; r++) begin : g_reg
        localparam bit VALID = (r / NREG) < NBANK;
        localparam bit HARD0 = ZERO_HARD && (r == 0);
        assign addr_ok[r] = VALID;
        if (VALID && !HARD0) begin : g_cnt
            sb_counter #(.LAT_W(LAT_W)) u_cnt (
                .clk      (clk),
                .rst      (rst),
                .clear    (bus.flush),
                .load     (accept && bus.iss_we && (bus.iss_dst == AW'(r))),
                .load_val (load_val),
                .wb_clr   (bus.wb_en && (bus.wb_dst == AW'(r))),
                .cnt      (cnt[r])
            );
        end else begin : g_tie
            assign cnt[r] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NTOT; r++)
                mem[r] <= '0;
        end else if (bus.wb_en && addr_ok[bus.wb_dst] && !is_hard0(bus.wb_dst)) begin
            mem[bus.wb_dst] <= bus.wb_data;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit;
        assign a   = bus.rd_addr[i*AW +: AW];
        assign hit = bus.wb_en && (bus.wb_dst == a) && addr_ok[a];
        assign rd_data_v[i]  = (!addr_ok[a] || is_hard0(a)) ? '0 : (hit ? bus.wb_data : mem[a]);
        assign rd_ready_v[i] = !addr_ok[a] || (cnt[a] == '0) || hit;
    end

    assign bus.rd_data  = rd_data_v;
    assign bus.rd_ready = rd_ready_v;

    // A result landing this cycle resolves both the RAW and the WAW hazard on its register.
    assign dst_hit   = bus.wb_en && (bus.wb_dst == bus.iss_dst);
    assign raw       = |(bus.rd_used & ~rd_ready_v);
    assign waw       = bus.iss_we && (cnt[bus.iss_dst] != '0) && !dst_hit;
    assign stall_int = bus.iss_valid && (raw || waw);
    assign bus.stall = stall_int;
    assign accept    = bus.iss_valid && !stall_int && !bus.flush;
    assign load_val  = (bus.iss_lat == '0) ? LAT_W'(1) : bus.iss_lat;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized check of regfile_scoreboard against an array-based reference model,
// preceded by directed hazard, bypass, zero-register, flush and reset scenarios.
module tb_regfile_scoreboard;
    import regfile_scoreboard_pkg::*;

    localparam int XLEN  = DEF_XLEN;
    localparam int AW    = DEF_AW;
    localparam int NREAD = DEF_NREAD;
    localparam int LAT_W = DEF_LAT_W;
    localparam int NTOT  = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_scoreboard_if #(.XLEN(XLEN), .AW(AW), .NREAD(NREAD), .LAT_W(LAT_W)) bus ();

    regfile_scoreboard #(
        .XLEN(XLEN), .NREG(DEF_NREG), .NBANK(DEF_NBANK), .NREAD(NREAD), .LAT_W(LAT_W), .ZERO_HARD(1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    logic [XLEN-1:0] m_mem [NTOT];
    int              m_cnt [NTOT];

    typedef struct packed {
        logic                  rst;
        logic                  iss_valid;
        logic                  iss_we;
        logic [AW-1:0]         iss_dst;
        logic [LAT_W-1:0]      iss_lat;
        logic [NREAD-1:0]      rd_used;
        logic [NREAD*AW-1:0]   rd_addr;
        logic                  wb_en;
        logic [AW-1:0]         wb_dst;
        logic [XLEN-1:0]       wb_data;
        logic                  flush;
    } stim_t;

    stim_t s;

    function automatic stim_t idle();
        stim_t t;
        t = '0;
        return t;
    endfunction

    task automatic applyStimulus(input stim_t t);
        rst           = t.rst;
        bus.iss_valid = t.iss_valid;
        bus.iss_we    = t.iss_we;
        bus.iss_dst   = t.iss_dst;
        bus.iss_lat   = t.iss_lat;
        bus.rd_used   = t.rd_used;
        bus.rd_addr   = t.rd_addr;
        bus.wb_en     = t.wb_en;
        bus.wb_dst    = t.wb_dst;
        bus.wb_data   = t.wb_data;
        bus.flush     = t.flush;
    endtask

    task automatic checkOutput(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = '0;
        a[AW-1] = 1'($urandom_range(0, 1));
        a[2:0]  = 3'($urandom_range(0, 7));
        return a;
    endfunction

    // Reference model: register contents plus remaining cycles until each result is ready.
    function automatic bit m_hit(input logic [AW-1:0] a);
        return (bus.wb_en === 1'b1) && (bus.wb_dst == a);
    endfunction

    function automatic logic [XLEN-1:0] m_rdata(input logic [AW-1:0] a);
        if (a == '0) return '0;
        if (m_hit(a)) return bus.wb_data;
        return m_mem[a];
    endfunction

    function automatic bit m_rready(input logic [AW-1:0] a);
        return (a == '0) || (m_cnt[a] == 0) || m_hit(a);
    endfunction

    function automatic bit m_stall();
        if (bus.iss_valid !== 1'b1) return 1'b0;
        for (int i = 0; i < NREAD; i++)
            if (bus.rd_used[i] && !m_rready(bus.rd_addr[i*AW +: AW])) return 1'b1;
        if (bus.iss_we && (m_cnt[bus.iss_dst] != 0) && !m_hit(bus.iss_dst)) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        bit acc;
        int lat;
        if (rst) begin
            for (int r = 0; r < NTOT; r++) begin
                m_mem[r] = '0;
                m_cnt[r] = 0;
            end
        end else begin
            acc = bus.iss_valid && !m_stall() && !bus.flush;
            lat = (bus.iss_lat == '0) ? 1 : int'(bus.iss_lat);
            for (int r = 0; r < NTOT; r++) begin
                if (bus.flush)
                    m_cnt[r] = 0;
                else if (r != 0 && acc && bus.iss_we && bus.iss_dst == AW'(r))
                    m_cnt[r] = lat;
                else if (m_hit(AW'(r)))
                    m_cnt[r] = 0;
                else if (m_cnt[r] > 0)
                    m_cnt[r] = m_cnt[r] - 1;
            end
            if (bus.wb_en && bus.wb_dst != '0)
                m_mem[bus.wb_dst] = bus.wb_data;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < NREAD; i++) begin
                checkOutput($sformatf("model rd_data[%0d]", i), bus.rd_data[i*XLEN +: XLEN],
                            m_rdata(bus.rd_addr[i*AW +: AW]));
                checkOutput($sformatf("model rd_ready[%0d]", i), XLEN'(bus.rd_ready[i]),
                            XLEN'(m_rready(bus.rd_addr[i*AW +: AW])));
            end
            checkOutput("model stall", XLEN'(bus.stall), XLEN'(m_stall()));
        end
    end

    initial begin
        s = idle();
        s.rst = 1'b1;
        applyStimulus(s);
        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b1;

        s.rd_addr = {6'h07, 6'h25, 6'h05};
        s.rd_used = 3'b111;
        s.iss_valid = 1'b1;
        s.iss_we = 1'b1;
        s.iss_dst = 6'h07;
        s.iss_lat = LAT_FPU;
        applyStimulus(s);
        @(negedge clk);
        checkOutput("reset rd_data", XLEN'(bus.rd_data != '0), 32'h0);
        checkOutput("reset rd_ready", XLEN'(bus.rd_ready), 32'h7);
        checkOutput("reset stall", XLEN'(bus.stall), 32'h0);
        next_cycle();

        // RAW on a load result, resolved by the write-back bypass
        s = idle();
        s.iss_valid = 1'b1; s.iss_we = 1'b1; s.iss_dst = 6'h05; s.iss_lat = LAT_LOAD;
        applyStimulus(s);
        @(negedge clk);
        checkOutput("raw issue stall", XLEN'(bus.stall), 32'h0);
        next_cycle();
        s = idle();
        s.iss_valid = 1'b1; s.rd_addr[5:0] = 6'h05; s.rd_used = 3'b001;
        applyStimulus(s);
        @(negedge clk);
        checkOutput("raw stall c1", XLEN'(bus.stall), 32'h1);
        checkOutput("raw ready c1", XLEN'(bus.rd_ready[0]), 32'h0);
        next_cycle();
        @(negedge clk);
        checkOutput("raw stall c2", XLEN'(bus.stall), 32'h1);
        next_cycle();
        s.wb_en = 1'b1; s.wb_dst = 6'h05; s.wb_data = 32'h1234_5678;
        applyStimulus(s);
        @(negedge clk);
        checkOutput("raw stall c3", XLEN'(bus.stall), 32'h0);
        checkOutput("raw bypass data", bus.rd_data[31:0], 32'h1234_5678);
        next_cycle();
        s = idle();
        s.rd_addr[5:0] = 6'h05;
        applyStimulus(s);
        @(negedge clk);
        checkOutput("raw array data", bus.rd_data[31:0], 32'h1234_5678);
        next_cycle();

        // FPR result bypassed on the write-back cycle
        s = idle();
        s.iss_valid = 1'b1; s.iss_we = 1'b1; s.iss_dst = 6'h25; s.iss_lat = LAT_FPU;
        applyStimulus(s);
        next_cycle();
        s = idle();
        s.rd_addr = {6'h00, 6'h25, 6'h25};
        applyStimulus(s);
        @(negedge clk);
        checkOutput("fpr pending ready", XLEN'(bus.rd_ready), 32'h4);
        next_cycle();
        s.wb_en = 1'b1; s.wb_dst = 6'h25; s.wb_data = 32'h3f80_0000;
        applyStimulus(s);
        @(negedge clk);
        checkOutput("fpr bypass port0", bus.rd_data[31:0], 32'h3f80_0000);
        checkOutput("fpr bypass port1", bus.rd_data[63:32], 32'h3f80_0000);
        checkOutput("fpr bypass ready", XLEN'(bus.rd_ready), 32'h7);
        next_cycle();
        s.wb_en = 1'b0;
        applyStimulus(s);
        @(negedge clk);
        checkOutput("fpr cleared ready", XLEN'(bus.rd_ready), 32'h7);
        next_cycle();

        // Hardwired zero register
        s = idle();
        s.wb_en = 1'b1; s.wb_dst = 6'h00; s.wb_data = 32'hdead_beef;
        applyStimulus(s);
        @(negedge clk);
        checkOutput("zero bypass data", bus.rd_data[31:0], 32'h0);
        next_cycle();
        s = idle();
        s.iss_valid = 1'b1; s.iss_we = 1'b1; s.iss_dst = 6'h00; s.iss_lat = LAT_FPU;
        applyStimulus(s);
        @(negedge clk);
        checkOutput("zero array data", bus.rd_data[31:0], 32'h0);
        next_cycle();
        s = idle();
        s.iss_valid = 1'b1; s.rd_used = 3'b001;
        applyStimulus(s);
        @(negedge clk);
        checkOutput("zero never pending", XLEN'(bus.stall), 32'h0);
        next_cycle();

        // WAW on GPR7, released by its write-back while the new reservation takes over
        s = idle();
        s.iss_valid = 1'b1; s.iss_we = 1'b1; s.iss_dst = 6'h07; s.iss_lat = LAT_FPU;
        applyStimulus(s);
        next_cycle();
        s.iss_lat = LAT_ALU;
        applyStimulus(s);
        @(negedge clk);
        checkOutput("waw stall c1", XLEN'(bus.stall), 32'h1);
        next_cycle();
        @(negedge clk);
        checkOutput("waw stall c2", XLEN'(bus.stall), 32'h1);
        next_cycle();
        s.wb_en = 1'b1; s.wb_dst = 6'h07; s.wb_data = 32'ha5a5_a5a5;
        applyStimulus(s);
        @(negedge clk);
        checkOutput("waw wb release", XLEN'(bus.stall), 32'h0);
        next_cycle();
        s = idle();
        s.rd_addr[5:0] = 6'h07;
        applyStimulus(s);
        @(negedge clk);
        checkOutput("waw new reservation", XLEN'(bus.rd_ready[0]), 32'h0);
        next_cycle();
        @(negedge clk);
        checkOutput("waw expired ready", XLEN'(bus.rd_ready[0]), 32'h1);
        checkOutput("waw written data", bus.rd_data[31:0], 32'ha5a5_a5a5);
        next_cycle();

        // Flush cancels a same-cycle reservation; reset clears a running one
        s = idle();
        s.iss_valid = 1'b1; s.iss_we = 1'b1; s.iss_dst = 6'h09; s.iss_lat = LAT_FPU; s.flush = 1'b1;
        applyStimulus(s);
        next_cycle();
        s = idle();
        s.iss_valid = 1'b1; s.iss_we = 1'b1; s.iss_dst = 6'h0a; s.iss_lat = LAT_FPU;
        s.rd_addr[5:0] = 6'h09; s.rd_used = 3'b001;
        applyStimulus(s);
        @(negedge clk);
        checkOutput("flush cancels issue", XLEN'(bus.stall), 32'h0);
        next_cycle();
        s = idle();
        s.rst = 1'b1;
        s.rd_addr = {6'h00, 6'h0a, 6'h09};
        applyStimulus(s);
        @(negedge clk);
        checkOutput("pre-reset ready", XLEN'(bus.rd_ready), 32'h5);
        next_cycle();
        s.rst = 1'b0;
        s.rd_addr = {6'h05, 6'h0a, 6'h09};
        applyStimulus(s);
        @(negedge clk);
        checkOutput("post-reset ready", XLEN'(bus.rd_ready), 32'h7);
        checkOutput("post-reset data", bus.rd_data[95:64], 32'h0);
        next_cycle();

        for (int n = 0; n < 3000; n++) begin
            s = idle();
            s.rst       = ($urandom_range(0, 199) == 0);
            s.flush     = ($urandom_range(0, 31) == 0);
            s.iss_valid = ($urandom_range(0, 3) != 0);
            s.iss_we    = 1'($urandom_range(0, 1));
            s.iss_dst   = rand_addr();
            s.iss_lat   = LAT_W'($urandom_range(0, 7));
            s.rd_used   = NREAD'($urandom_range(0, 7));
            for (int i = 0; i < NREAD; i++)
                s.rd_addr[i*AW +: AW] = rand_addr();
            s.wb_en     = ($urandom_range(0, 2) == 0);
            s.wb_dst    = rand_addr();
            s.wb_data   = $urandom;
            applyStimulus(s);
            next_cycle();
        end

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
